// File: rtl/store_merge.sv
// Sub-word store engine in front of a word-only DTCM: byte/halfword stores are
// widened by read-modify-write; aligned word stores may skip the read-back.
module store_merge #(
  parameter int ADDR_W  = 32,
  parameter bit SW_FAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        RW_type,
  output logic [ADDR_W-1:0] dtcm_addr,
  output logic              dtcm_rd_en,
  input  logic [31:0]       dtcm_rdata,
  output logic              dtcm_wr_en,
  output logic [31:0]       dtcm_wdata,
  output logic              st_done,
  output logic              st_misalign
);

  localparam logic [2:0] RW_SB = 3'b000;
  localparam logic [2:0] RW_SH = 3'b001;
  localparam logic [2:0] RW_SW = 3'b010;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              req_bad;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] word_addr;

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Checked against the live request so a bad store is rejected at the accept edge.
  always_comb begin
    req_bad = 1'b0;
    case (RW_type)
      RW_SB:   req_bad = 1'b0;
      RW_SH:   req_bad = st_addr[0];
      RW_SW:   req_bad = (st_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Lanes outside the addressed one pass the DTCM word through untouched.
  always_comb begin
    merged = dtcm_rdata;
    case (type_q)
      RW_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      RW_SH:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

  // NOTE: every output and next-state value is given a default before the case,
  // so no path through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    type_d      = type_q;
    wdata_d     = wdata_q;
    st_ready    = 1'b0;
    dtcm_rd_en  = 1'b0;
    dtcm_wr_en  = 1'b0;
    dtcm_addr   = '0;
    dtcm_wdata  = '0;
    st_done     = 1'b0;
    st_misalign = 1'b0;

    case (state_q)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          addr_d  = st_addr;
          data_d  = st_data;
          type_d  = RW_type;
          wdata_d = st_data;
          if (req_bad)
            state_d = ERR;
          else if (SW_FAST && RW_type == RW_SW)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        dtcm_rd_en = 1'b1;
        dtcm_addr  = word_addr;
        state_d    = MRG;
      end
      MRG: begin
        wdata_d = merged;
        state_d = WR;
      end
      WR: begin
        dtcm_wr_en = 1'b1;
        dtcm_addr  = word_addr;
        dtcm_wdata = wdata_q;
        st_done    = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        st_misalign = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Scoreboard bench for store_merge: a word-addressed memory model predicts every
// DTCM read, merged write and reject, and a monitor matches them as they appear.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  rw_type;
  logic [31:0] dtcm_addr;
  logic        dtcm_rd_en;
  logic [31:0] dtcm_rdata;
  logic        dtcm_wr_en;
  logic [31:0] dtcm_wdata;
  logic        st_done;
  logic        st_misalign;

  store_merge #(.ADDR_W(32), .SW_FAST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .RW_type    (rw_type),
    .dtcm_addr  (dtcm_addr),
    .dtcm_rd_en (dtcm_rd_en),
    .dtcm_rdata (dtcm_rdata),
    .dtcm_wr_en (dtcm_wr_en),
    .dtcm_wdata (dtcm_wdata),
    .st_done    (st_done),
    .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        rd_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          prev_acc = 0;
  int          prev_gap = 0;
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Memory behind the DUT: read data shows up the cycle after the strobe and is
  // garbage otherwise, so a late capture is visible.
  always @(posedge clk) begin
    if (dtcm_rd_en) dtcm_rdata <= dmem[dtcm_addr[9:2]];
    else            dtcm_rdata <= $urandom;
    if (dtcm_wr_en) dmem[dtcm_addr[9:2]] <= dtcm_wdata;
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [2:0] t,
                                            input logic [31:0] a, input logic [31:0] d);
    int          sh;
    logic [31:0] mask;
    case (t)
      3'd0: begin sh = 8 * int'(a[1:0]); mask = 32'hFF << sh;
                  return (old & ~mask) | ((d & 32'hFF) << sh); end
      3'd1: begin sh = a[1] ? 16 : 0; mask = 32'hFFFF << sh;
                  return (old & ~mask) | ((d & 32'hFFFF) << sh); end
      default: return d;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, halfway between active edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("rd_wr_overlap", {31'd0, dtcm_rd_en & dtcm_wr_en}, 32'd0);
      if (!dtcm_wr_en) check("wdata_idle_zero", dtcm_wdata, 32'd0);
      if (st_done && !dtcm_wr_en) check("done_without_write", 32'd1, 32'd0);
      if (dtcm_rd_en) begin
        if (rd_q.size() == 0) check("unexpected_read", dtcm_addr, 32'hFFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          check("read_addr", dtcm_addr, e.addr);
          check("read_cycle", edge_cnt, e.at);
        end
      end
      if (dtcm_wr_en || st_misalign) begin
        if (exp_q.size() == 0) check("unexpected_event", {dtcm_wr_en, st_misalign}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("event_kind", {31'd0, st_misalign}, {31'd0, e.is_err});
          check("event_cycle", edge_cnt, e.at);
          if (!e.is_err) begin
            check("write_addr", dtcm_addr, e.addr);
            check("write_data", dtcm_wdata, e.data);
            check("write_done", {31'd0, st_done}, 32'd1);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      st_valid = 1'b0;
      st_addr  = $urandom;
      st_data  = $urandom;
      rw_type  = 3'($urandom);
    end
  endtask

  // Presents a request (st_valid held high while blocked) and predicts its outcome.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                       input bit b2b);
    int          polls = 0;
    bit          got   = 0;
    int          acc;
    exp_t        e;
    logic [31:0] wa;
    bit          bad;
    while (!got && polls < 30) begin
      @(negedge clk); #1;
      st_valid = 1'b1; st_addr = a; st_data = d; rw_type = t;
      if (st_ready) got = 1;
      else polls++;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: st_ready=%0b expected 1 within 30 cycles", st_ready);
      st_valid = 1'b0;
      return;
    end
    acc = edge_cnt + 1;
    if (b2b && polls > 0) check("accept_spacing", acc - prev_acc, prev_gap);
    wa  = {a[31:2], 2'b00};
    bad = (t > 3'd2) || (t == 3'd1 && a[0]) || (t == 3'd2 && a[1:0] != 2'b00);
    if (bad) begin
      e = '{1'b1, 32'd0, 32'd0, acc};
      exp_q.push_back(e);
      prev_gap = 2;
    end else if (t == 3'd2) begin
      e = '{1'b0, wa, d, acc};
      exp_q.push_back(e);
      ref_mem[a[9:2]] = d;
      prev_gap = 2;
    end else begin
      e = '{1'b0, wa, 32'd0, acc};
      rd_q.push_back(e);
      ref_mem[a[9:2]] = ref_merge(ref_mem[a[9:2]], t, a, d);
      e = '{1'b0, wa, ref_mem[a[9:2]], acc + 2};
      exp_q.push_back(e);
      prev_gap = 4;
    end
    prev_acc = acc;
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_st_ready"},    {31'd0, st_ready},    32'd1);
    check({tag, "_rd_en"},       {31'd0, dtcm_rd_en},  32'd0);
    check({tag, "_wr_en"},       {31'd0, dtcm_wr_en},  32'd0);
    check({tag, "_st_done"},     {31'd0, st_done},     32'd0);
    check({tag, "_st_misalign"}, {31'd0, st_misalign}, 32'd0);
    check({tag, "_dtcm_addr"},   dtcm_addr,            32'd0);
    check({tag, "_dtcm_wdata"},  dtcm_wdata,           32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  t;
    exp_t        e;
    int          r;

    for (int i = 0; i < 256; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[8'h40] = 32'h1122_3344; ref_mem[8'h40] = 32'h1122_3344;
    dmem[8'h80] = 32'hAAAA_5555; ref_mem[8'h80] = 32'hAAAA_5555;

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; rw_type = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed: byte and halfword RMW, fast word write, rejects.
    issue(3'b000, 32'h0000_0102, 32'hFFFF_FFAB, 1'b0);
    issue(3'b001, 32'h0000_0202, 32'h0000_BEEF, 1'b1);
    issue(3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 1'b1);
    issue(3'b001, 32'h0000_0101, 32'h1234_5678, 1'b1);
    issue(3'b010, 32'h0000_0102, 32'h1234_5678, 1'b1);
    issue(3'b011, 32'h0000_0100, 32'h1234_5678, 1'b1);
    issue(3'b010, 32'h0000_0304, 32'h0BAD_F00D, 1'b1);
    idle(6);

    // Reset in the middle of a byte store: the read happens, the write never does.
    @(negedge clk); #1;
    st_valid = 1'b1; st_addr = 32'h0000_0104; st_data = 32'h0000_00C3; rw_type = 3'b000;
    check("pre_abort_ready", {31'd0, st_ready}, 32'd1);
    e = '{1'b0, 32'h0000_0104, 32'd0, edge_cnt + 1};
    rd_q.push_back(e);
    @(negedge clk); #1 st_valid = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    issue(3'b000, 32'h0000_0105, 32'h0000_005A, 1'b0);
    idle(2);

    // Random traffic, mostly back-to-back with st_valid held high.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      a = {$urandom_range(0, 15), 28'h000_0100} | 32'($urandom_range(0, 31));
      d = $urandom;
      if (r < 3)       t = 3'b000;
      else if (r < 6)  t = 3'b001;
      else if (r < 9)  t = 3'b010;
      else             t = 3'($urandom_range(3, 7));
      if (t != 3'b000 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) begin
        idle($urandom_range(1, 3));
        issue(t, a, d, 1'b0);
      end else begin
        issue(t, a, d, 1'b1);
      end
    end
    idle(10);

    check("pending_events", exp_q.size(), 32'd0);
    check("pending_reads", rd_q.size(), 32'd0);
    for (int i = 0; i < 256; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of store and DTCM byte addresses.
REQ-002 SHALL have parameter SW_FAST, default 1; 1 = aligned SW bypasses read-back, 0 = SW also runs read-modify-write.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request valid
- st_ready  output  1  block can accept a request
- st_addr  input  ADDR_W  store byte address
- st_data  input  32  store data, right-justified
- RW_type  input  3  000 SB, 001 SH, 010 SW; all other codes illegal
- dtcm_addr  output  ADDR_W  word-aligned DTCM address, bits [1:0] = 0
- dtcm_rd_en  output  1  DTCM word read strobe
- dtcm_rdata  input  32  DTCM read data, valid the cycle after dtcm_rd_en
- dtcm_wr_en  output  1  DTCM full-word write strobe
- dtcm_wdata  output  32  merged write word
- st_done  output  1  one-cycle pulse, store committed
- st_misalign  output  1  one-cycle pulse, request rejected

Function
REQ-005 SHALL implement FSM states IDLE, RD, MRG, WR, ERR.
REQ-006 SHALL hold st_ready = 1 only in IDLE, so at most one store is outstanding.
REQ-007 SHALL accept a request on a rising edge where st_valid & st_ready, and register st_addr, st_data and RW_type at that edge.
REQ-008 SHALL reject a request (IDLE->ERR) on any of:
- SH with addr[0] = 1
- SW with addr[1:0] != 0
- illegal RW_type
REQ-009 In ERR, SHALL pulse st_misalign for exactly one cycle, issue no DTCM access, then go to IDLE.
REQ-010 Aligned SW with SW_FAST = 1 SHALL go IDLE->WR; every other accepted store SHALL go IDLE->RD->MRG->WR->IDLE.
REQ-011 In RD, SHALL assert dtcm_rd_en for exactly one cycle with dtcm_addr = {addr[ADDR_W-1:2], 2'b00}.
REQ-012 In MRG, SHALL capture dtcm_rdata and replace the addressed lane:
- SB: byte lane addr[1:0] <- st_data[7:0]
- SH: halfword lane addr[1] <- st_data[15:0]
- SW: whole word <- st_data
- all other lanes keep dtcm_rdata unchanged
REQ-013 In WR, SHALL assert dtcm_wr_en and st_done for exactly one cycle, with dtcm_addr word-aligned and dtcm_wdata = the merged word (st_data for fast SW).
REQ-014 Latency from the accept edge at cycle T:
- fast SW: write in cycle T+1
- RMW: read in T+1, merge in T+2, write in T+3
- reject: st_misalign in T+1
REQ-015 st_ready SHALL return to 1 in the cycle after WR or ERR; back-to-back requests SHALL therefore be spaced at least 2 (fast SW) or 4 (RMW) cycles apart.
REQ-016 dtcm_rd_en and dtcm_wr_en SHALL never be asserted in the same cycle.
REQ-017 dtcm_wdata SHALL be 0 whenever dtcm_wr_en = 0.
REQ-018 Changes on st_* inputs while not in IDLE SHALL have no effect.
REQ-019 The unused bits (higher than the lane width) of st_data SHALL be ignored for SB and SH.

Reset
REQ-020 While rst_n = 0, SHALL force state IDLE, and outputs:
- st_ready = 1
- dtcm_rd_en, dtcm_wr_en, st_done, st_misalign = 0
- dtcm_addr = 0, dtcm_wdata = 0
REQ-021 Reset asserted mid-operation (RD, MRG or WR) SHALL abort the store with no later DTCM write; after rst_n rises, the first rising edge SHALL see the block in IDLE.

Verification
REQ-022 SB, addr 0x0000_0102, st_data 0xFFFF_FFAB, memory word 0x1122_3344 -> read at 0x100; write 0x11AB_3344 at T+3; st_done at T+3.
REQ-023 SH, addr 0x0000_0202, st_data 0x0000_BEEF, memory word 0xAAAA_5555 -> write 0xBEEF_5555 at 0x200.
REQ-024 SW, addr 0x0000_0300, data 0xDEAD_BEEF, SW_FAST = 1 -> no read; write at T+1; st_ready = 1 at T+2.
REQ-025 SH at 0x0000_0101, SW at 0x0000_0102, and RW_type 011 -> st_misalign pulse at T+1; no dtcm_rd_en or dtcm_wr_en.
REQ-026 rst_n driven low during MRG of an SB -> dtcm_wr_en never asserts; outputs take reset values immediately; next SB completes normally.
REQ-027 Back-to-back requests with st_valid held high -> second accept at T+4 (RMW) or T+2 (fast SW); dtcm_rd_en and dtcm_wr_en never overlap.
